pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer_pkg.sv | 5 +
 rtl/pipeline_sequencer_dmem_handshake.sv | 27 ++
 rtl/pipeline_sequencer.sv | 114 +++++++++++
 tb/tb_pipeline_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg: shared sequencer state encoding and default memory timeout
package pipeline_sequencer_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} seq_state_e;
    localparam int DEFAULT_MEM_TIMEOUT = 255;
endpackage

// File: rtl/pipeline_sequencer_dmem_handshake.sv
// dmem_handshake: data-memory stall detection and MEM_WAIT timeout counter
module dmem_handshake
    import pipeline_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic       clk,
    input  logic       n_reset,
    input  seq_state_e state,
    input  logic       mem_op,
    input  logic       ack,
    output logic       mem_stall,
    output logic       timeout
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic waiting;
    assign waiting   = (state == MEM_WAIT) && !ack;
    assign mem_stall = ((state == RUN) && mem_op && !ack) || waiting;
    // the cycle that would push the count to MEM_TIMEOUT is the last one spent waiting
    assign timeout   = waiting && (wait_cnt == TW'(MEM_TIMEOUT - 1));
    // count unacknowledged MEM_WAIT cycles; any other cycle clears the count
    always_ff @(posedge clk) begin
        if (!n_reset) wait_cnt <= '0;
        else          wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: pipeline stall/flush sequencer; PIPELINE_PERF_CNT_EN enables saturating perf counters
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             bubble_i,
    input  logic             branch_taken_i,
    input  logic             mem_op_xm_i,
    input  logic             dmem_ack_i,
    input  logic             halt_i,
    output logic             dmem_req_o,
    output logic             pc_en_o,
    output logic             fd_en_o,
    output logic             dx_en_o,
    output logic             xm_en_o,
    output logic             fd_flush_o,
    output logic             dx_flush_o,
    output logic             xm_flush_o,
    output logic             mw_flush_o,
    output logic             halted_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    seq_state_e state;
    logic mem_stall, timeout, take_branch;

    dmem_handshake #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_hs (
        .clk       (clk),
        .n_reset   (n_reset),
        .state     (state),
        .mem_op    (mem_op_xm_i),
        .ack       (dmem_ack_i),
        .mem_stall (mem_stall),
        .timeout   (timeout)
    );

    // a branch is honoured only when neither a memory stall nor a bubble masks it
    assign take_branch = n_reset && (state == RUN) && !mem_stall && !bubble_i && branch_taken_i;

    // enables, flushes and memory request decoded from state and current inputs
    always_comb begin
        dmem_req_o = 1'b0;
        {pc_en_o, fd_en_o, dx_en_o, xm_en_o} = 4'b0000;
        {fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o} = 4'b0000;
        if (!n_reset) begin
            {fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o} = 4'b1111;
        end else if (state == RUN) begin
            dmem_req_o = mem_op_xm_i;
            if (mem_stall) begin
                mw_flush_o = 1'b1;
            end else if (bubble_i) begin
                xm_en_o    = 1'b1;
                xm_flush_o = 1'b1;
            end else begin
                {pc_en_o, fd_en_o, dx_en_o, xm_en_o} = 4'b1111;
                fd_flush_o = take_branch;
                dx_flush_o = take_branch;
            end
        end else if (state == MEM_WAIT) begin
            dmem_req_o = 1'b1;
            mw_flush_o = mem_stall;
            {pc_en_o, fd_en_o, dx_en_o, xm_en_o} = {4{!mem_stall}};
        end
    end

    // sequencer FSM with registered halt and timeout flags; HALTED and ERROR hold until reset
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state         <= RUN;
            halted_o      <= 1'b0;
            mem_timeout_o <= 1'b0;
        end else if (state == RUN) begin
            if (mem_stall) begin
                state <= MEM_WAIT;
            end else if (!bubble_i && !branch_taken_i && halt_i) begin
                state    <= HALTED;
                halted_o <= 1'b1;
            end
        end else if (state == MEM_WAIT) begin
            if (timeout) begin
                state         <= ERROR;
                mem_timeout_o <= 1'b1;
            end else if (!mem_stall) begin
                state <= RUN;
            end
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic stall_ev;
    assign stall_ev    = ((state == RUN) || (state == MEM_WAIT)) && !pc_en_o;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
    // saturating counts of frozen-PC cycles and honoured branch flushes
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (take_branch && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed scoreboard bench for pipeline_sequencer
module tb_pipeline_sequencer;
    logic clk = 1'b0;
    logic n_reset = 1'b0, bubble_i = 1'b0, branch_taken_i = 1'b0;
    logic mem_op_xm_i = 1'b0, dmem_ack_i = 1'b0, halt_i = 1'b0;
    logic dmem_req_o, pc_en_o, fd_en_o, dx_en_o, xm_en_o;
    logic fd_flush_o, dx_flush_o, xm_flush_o, mw_flush_o, halted_o, mem_timeout_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    typedef struct {
        string       name;
        logic [42:0] want;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bubble_i       (bubble_i),
        .branch_taken_i (branch_taken_i),
        .mem_op_xm_i    (mem_op_xm_i),
        .dmem_ack_i     (dmem_ack_i),
        .halt_i         (halt_i),
        .dmem_req_o     (dmem_req_o),
        .pc_en_o        (pc_en_o),
        .fd_en_o        (fd_en_o),
        .dx_en_o        (dx_en_o),
        .xm_en_o        (xm_en_o),
        .fd_flush_o     (fd_flush_o),
        .dx_flush_o     (dx_flush_o),
        .xm_flush_o     (xm_flush_o),
        .mw_flush_o     (mw_flush_o),
        .halted_o       (halted_o),
        .mem_timeout_o  (mem_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // drive one cycle of inputs and queue the outputs expected during that cycle
    // en = {pc,fd,dx,xm}, fl = {fd,dx,xm,mw}; counters are those visible during the cycle
    task automatic step(input string name, input logic rst, bub, br, mem, ack, halt,
                        input logic [3:0] en, fl, input logic req, h, t, input int sc, fc);
        exp_t e;
        logic [15:0] s, f;
        @(posedge clk);
        #1;
        n_reset = rst; bubble_i = bub; branch_taken_i = br;
        mem_op_xm_i = mem; dmem_ack_i = ack; halt_i = halt;
`ifdef PIPELINE_PERF_CNT_EN
        s = 16'(sc); f = 16'(fc);
`else
        s = 16'd0; f = 16'd0;
`endif
        e.name = name;
        e.want = {en, fl, req, h, t, s, f};
        sb.push_back(e);
    endtask

    // monitor: compare every queued expectation mid-cycle, away from the clock edge
    initial begin
        exp_t e;
        logic [42:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {pc_en_o, fd_en_o, dx_en_o, xm_en_o, fd_flush_o, dx_flush_o, xm_flush_o,
                       mw_flush_o, dmem_req_o, halted_o, mem_timeout_o, stall_cnt_o, flush_cnt_o};
                checks++;
                if (got !== e.want) begin
                    errors++;
                    $display("FAIL %s got=%h expected=%h", e.name, got, e.want);
                end
            end
        end
    end

    initial begin
        //    name          rst bub br mem ack hlt  en       fl      req h  t  sc fc
        step("reset0",      0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0);
        step("reset_memop", 0, 0, 0, 1, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0);
        step("idle",        1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        step("ld_same_ack", 1, 0, 0, 1, 1, 0, 4'b1111, 4'b0000, 1, 0, 0, 0, 0);
        step("after_ld",    1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        step("ld_stall",    1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0);
        step("mw_1",        1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 1, 0);
        step("mw_2",        1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 2, 0);
        step("mw_ack",      1, 0, 0, 1, 1, 0, 4'b1111, 4'b0000, 1, 0, 0, 3, 0);
        step("run_after",   1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 3, 0);
        step("bubble_br",   1, 1, 1, 0, 0, 0, 4'b0001, 4'b0010, 0, 0, 0, 3, 0);
        step("branch",      1, 0, 1, 0, 0, 0, 4'b1111, 4'b1100, 0, 0, 0, 4, 0);
        step("post_branch", 1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4, 1);
        step("ld_halt",     1, 0, 0, 1, 0, 1, 4'b0000, 4'b0001, 1, 0, 0, 4, 1);
        step("mw_halt",     1, 0, 0, 1, 0, 1, 4'b0000, 4'b0001, 1, 0, 0, 5, 1);
        step("mw_halt_ack", 1, 0, 0, 1, 1, 1, 4'b1111, 4'b0000, 1, 0, 0, 6, 1);
        step("run_halt",    1, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0, 0, 6, 1);
        step("halted",      1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 6, 1);
        step("halted_br",   1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 6, 1);
        step("rst_halt_a",  0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 1, 0, 6, 1);
        step("rst_halt_b",  0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0);
        step("ld_stall2",   1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0);
        step("mw_pre_rst",  1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 1, 0);
        step("rst_in_mw",   0, 0, 0, 1, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 2, 0);
        step("post_mw_rst", 1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        step("to_ld",       1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0);
        step("to_mw1",      1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 1, 0);
        step("to_mw2",      1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 2, 0);
        step("to_mw3",      1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 3, 0);
        step("to_mw4",      1, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 0, 0, 4, 0);
        step("error",       1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 1, 5, 0);
        step("error_hold",  1, 1, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 5, 0);
        step("rst_err_a",   0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 1, 5, 0);
        step("rst_err_b",   0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0);
        step("final_idle",  1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
